// File: rtl/scc_reg_pkg.sv
// SCC channel register file: shared address map, scan state and limits.
// Used by scc_channel_regs and scc_scan_sequencer.
package scc_reg_pkg;

  localparam int MAX_CH = 8;
  localparam int IDX_W  = $clog2(MAX_CH);

  localparam logic [7:0] ADDR_FREQ_BASE = 8'h00;
  localparam logic [7:0] ADDR_VOL_BASE  = 8'h10;
  localparam logic [7:0] ADDR_ENABLE    = 8'h1F;
  localparam logic [7:0] ADDR_MODE      = 8'h20;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/scc_scan_sequencer.sv
// Scan FSM: walks channel index 0..NUM_CH-1 once per slot_start.
// load/load_idx preview the next cycle so data can be registered alongside.
module scc_scan_sequencer
  import scc_reg_pkg::*;
#(
  parameter int NUM_CH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             slot_start,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output logic             load,
  output logic [IDX_W-1:0] load_idx
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

  scan_state_t      state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (slot_start) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (idx_q == LAST) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  assign valid    = (state_q == SCAN);
  assign idx      = idx_q;
  assign load     = (state_d == SCAN);
  assign load_idx = idx_d;

endmodule

// File: rtl/scc_channel_regs.sv
// SCC channel registers with scan output and phase-reset requests.
// Define SCC_REG_READBACK_EN to return stored values on reads.
module scc_channel_regs
  import scc_reg_pkg::*;
#(
  parameter int NUM_CH = 5,
  parameter int FREQ_W = 12,
  parameter int VOL_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_wrreq,
  input  logic              reg_rdreq,
  input  logic [7:0]        reg_address,
  input  logic [7:0]        reg_wrdata,
  output logic [7:0]        reg_rddata,
  output logic              reg_rddata_en,
  input  logic              slot_start,
  output logic              ch_valid,
  output logic [2:0]        ch_index,
  output logic [FREQ_W-1:0] ch_frequency_count,
  output logic [VOL_W-1:0]  ch_volume,
  output logic              ch_enable,
  output logic              ch_phase_reset,
  output logic              reg_freq_reset_mode
);

  localparam logic [3:0] CH_LIM = 4'(NUM_CH);

  logic [FREQ_W-1:0] freq [NUM_CH];
  logic [VOL_W-1:0]  vol  [NUM_CH];
  logic [NUM_CH-1:0] en;
  logic [NUM_CH-1:0] pend;
  logic [NUM_CH-1:0] pend_set;
  logic [NUM_CH-1:0] pend_clr;
  logic              mode;

  logic [IDX_W-1:0] f_ch;
  logic [IDX_W-1:0] v_ch;
  logic             f_hit;
  logic             v_hit;
  logic             en_hit;
  logic             mode_hit;
  logic             rd_go;
  logic [7:0]       rd_val;

  logic             seq_valid;
  logic [IDX_W-1:0] seq_idx;
  logic             load;
  logic [IDX_W-1:0] load_idx;

  scc_scan_sequencer #(
    .NUM_CH(NUM_CH)
  ) u_seq (
    .clk       (clk),
    .reset     (reset),
    .slot_start(slot_start),
    .valid     (seq_valid),
    .idx       (seq_idx),
    .load      (load),
    .load_idx  (load_idx)
  );

  assign f_ch     = reg_address[3:1];
  assign v_ch     = reg_address[2:0];
  assign f_hit    = (reg_address[7:4] == ADDR_FREQ_BASE[7:4])
                 && ({1'b0, f_ch} < CH_LIM);
  assign v_hit    = (reg_address[7:3] == ADDR_VOL_BASE[7:3])
                 && ({1'b0, v_ch} < CH_LIM);
  assign en_hit   = (reg_address == ADDR_ENABLE);
  assign mode_hit = (reg_address == ADDR_MODE);
  assign rd_go    = reg_rdreq & ~reg_wrreq;

  // A new request in the same cycle as the clear keeps the bit pending
  assign pend_set = (reg_wrreq && f_hit && mode)
                  ? (NUM_CH'(1) << f_ch) : '0;
  assign pend_clr = (ch_valid && ch_phase_reset)
                  ? (NUM_CH'(1) << ch_index) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        freq[i] <= '0;
        vol[i]  <= '0;
      end
      en   <= '0;
      mode <= 1'b0;
      pend <= '0;
    end else begin
      if (reg_wrreq) begin
        unique case (1'b1)
          f_hit: begin
            if (reg_address[0])
              freq[f_ch][FREQ_W-1:8] <= reg_wrdata[FREQ_W-9:0];
            else
              freq[f_ch][7:0] <= reg_wrdata;
          end
          v_hit:    vol[v_ch] <= reg_wrdata[VOL_W-1:0];
          en_hit:   en        <= reg_wrdata[NUM_CH-1:0];
          mode_hit: mode      <= reg_wrdata[5];
          default: ;
        endcase
      end
      pend <= (pend & ~pend_clr) | pend_set;
    end
  end

  always_comb begin
    rd_val = 8'hFF;
`ifdef SCC_REG_READBACK_EN
    unique case (1'b1)
      f_hit: begin
        if (reg_address[0])
          rd_val = 8'(freq[f_ch][FREQ_W-1:8]);
        else
          rd_val = freq[f_ch][7:0];
      end
      v_hit:    rd_val = 8'(vol[v_ch]);
      en_hit:   rd_val = 8'(en);
      mode_hit: rd_val = {2'b00, mode, 5'b00000};
      default:  rd_val = 8'hFF;
    endcase
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_rddata    <= '0;
      reg_rddata_en <= 1'b0;
    end else begin
      reg_rddata_en <= rd_go;
      if (rd_go)
        reg_rddata <= rd_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !load) begin
      ch_frequency_count <= '0;
      ch_volume          <= '0;
      ch_enable          <= 1'b0;
      ch_phase_reset     <= 1'b0;
    end else begin
      ch_frequency_count <= freq[load_idx];
      ch_volume          <= vol[load_idx];
      ch_enable          <= en[load_idx];
      ch_phase_reset     <= pend[load_idx];
    end
  end

  assign ch_valid            = seq_valid;
  assign ch_index            = seq_idx;
  assign reg_freq_reset_mode = mode;

endmodule
